seg_scan_capture: RTL and testbench

//  Receive side of the multiplexed 7-segment scan interface (an/ca, both active-low).

---
 rtl/seg_pkg.sv | 47 ++++
 rtl/seg_scan_capture_if.sv | 30 +++
 rtl/seg_code_decode.sv | 30 +++
 rtl/seg_scan_capture.sv | 176 +++++++++++++++++
 tb/tb_seg_scan_capture.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment scan interface.
// Used by the scan driver, the capture block and its bench.
package seg_pkg;

  localparam logic [7:0] SEG_CODE_0  = 8'h03;
  localparam logic [7:0] SEG_CODE_1  = 8'h9F;
  localparam logic [7:0] SEG_CODE_2  = 8'h25;
  localparam logic [7:0] SEG_CODE_3  = 8'h0D;
  localparam logic [7:0] SEG_CODE_4  = 8'h99;
  localparam logic [7:0] SEG_CODE_5  = 8'h49;
  localparam logic [7:0] SEG_CODE_6  = 8'hC1;
  localparam logic [7:0] SEG_CODE_6B = 8'h41;
  localparam logic [7:0] SEG_CODE_7  = 8'h1F;
  localparam logic [7:0] SEG_CODE_8  = 8'h01;
  localparam logic [7:0] SEG_CODE_9  = 8'h19;
  localparam logic [7:0] SEG_BLANK   = 8'hFF;

  localparam int AN_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } scan_state_t;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] ca;
  } scan_smp_t;

  function automatic logic one_hot_low(
    input logic [7:0] an
  );
    return $onehot(~an);
  endfunction

  function automatic logic [AN_IDX_W-1:0] an_index(
    input logic [7:0] an
  );
    logic [AN_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (!an[i]) idx = AN_IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Scan pins in, captured digit state and event pulses out.
// master drives the pins, slave is the capture block.
interface seg_scan_capture_if #(
  parameter int NUM_DIGITS = 8
);
  import seg_pkg::*;

  logic [7:0]              an;
  logic [7:0]              ca;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dig_valid;
  logic [NUM_DIGITS-1:0]   dp_out;
  logic                    upd;
  logic [AN_IDX_W-1:0]     upd_idx;
  logic                    seg_err;
  logic                    an_err;

  modport master (
    output an, ca,
    input  digits, dig_valid, dp_out,
    input  upd, upd_idx, seg_err, an_err
  );

  modport slave (
    input  an, ca,
    output digits, dig_valid, dp_out,
    output upd, upd_idx, seg_err, an_err
  );

endinterface

// File: rtl/seg_code_decode.sv
// Segment pattern (a..g, active-low) to BCD value.
// ok drops for any pattern outside the code table.
module seg_code_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       ok,
  output logic [3:0] value
);

  always_comb begin
    ok    = 1'b1;
    value = 4'd0;
    unique case (seg)
      SEG_CODE_0[7:1]: value = 4'd0;
      SEG_CODE_1[7:1]: value = 4'd1;
      SEG_CODE_2[7:1]: value = 4'd2;
      SEG_CODE_3[7:1]: value = 4'd3;
      SEG_CODE_4[7:1]: value = 4'd4;
      SEG_CODE_5[7:1]: value = 4'd5;
      SEG_CODE_6[7:1],
      SEG_CODE_6B[7:1]: value = 4'd6;
      SEG_CODE_7[7:1]: value = 4'd7;
      SEG_CODE_8[7:1]: value = 4'd8;
      SEG_CODE_9[7:1]: value = 4'd9;
      default:         ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Scan-pin monitor: waits for a stable slot, decodes it and
// keeps one BCD digit, dp and valid bit per anode position.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 65536
) (
  input logic clk,
  input logic rst_n,
  seg_scan_capture_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int IW = AN_IDX_W;

  scan_smp_t   s1, s2, snap;
  scan_state_t state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer [NUM_DIGITS];

  logic [NUM_DIGITS-1:0]   valid_q, dp_q, pend;
  logic [NUM_DIGITS-1:0]   tout, pend_all;
  logic [NUM_DIGITS-1:0]   pend_n, valid_n;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic                    upd_q, seg_err_q, an_err_q;
  logic [IW-1:0]           idx_q, k, sel;

  logic same, blank, good_an;
  logic cap, cap_en, cap_upd;
  logic dec_ok, sel_hit;
  logic [3:0] dec_val, cur_val;

  assign same    = (s2 == snap);
  assign blank   = (s2.an == SEG_BLANK);
  assign good_an = one_hot_low(s2.an);
  assign k       = an_index(snap.an);

  assign cap     = (state == SETTLE) && same &&
                   (cnt == CW'(STABLE_CYC));
  assign cap_en  = cap && !(&snap.an[NUM_DIGITS-1:0]);
  assign cur_val = digits_q[{k, 2'b00} +: 4];

  seg_code_decode u_dec (
    .seg   (snap.ca[7:1]),
    .ok    (dec_ok),
    .value (dec_val)
  );

  assign cap_upd = cap_en && (dec_ok ?
                   (!valid_q[k] || cur_val != dec_val) :
                   valid_q[k]);

  // A timeout colliding with a capture stays pending one more cycle
  always_comb begin
    tout    = '0;
    sel     = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      tout[i] = valid_q[i] &&
                timer[i] == TW'(TIMEOUT_CYC - 1) &&
                !(cap_en && IW'(i) == k);
    pend_all = pend | tout;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      if (pend_all[i]) begin
        sel     = IW'(i);
        sel_hit = 1'b1;
      end
    pend_n  = pend_all;
    valid_n = valid_q & ~tout;
    if (!cap_upd && sel_hit) pend_n[sel] = 1'b0;
    if (cap_en) begin
      valid_n[k] = dec_ok;
      if (dec_ok) pend_n[k] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= {SEG_BLANK, SEG_BLANK};
      s2       <= {SEG_BLANK, SEG_BLANK};
      snap     <= {SEG_BLANK, SEG_BLANK};
      state    <= IDLE;
      cnt      <= '0;
      an_err_q <= 1'b0;
    end else begin
      s1       <= {bus.an, bus.ca};
      s2       <= s1;
      an_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!blank) begin
            if (good_an) begin
              snap  <= s2;
              cnt   <= CW'(1);
              state <= SETTLE;
            end else begin
              an_err_q <= 1'b1;
            end
          end
        end
        SETTLE, HELD: begin
          if (!same) begin
            snap <= s2;
            cnt  <= CW'(1);
            if (blank) begin
              state <= IDLE;
            end else if (!good_an) begin
              an_err_q <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= SETTLE;
            end
          end else if (state == SETTLE) begin
            if (cnt == CW'(STABLE_CYC))
              state <= HELD;
            else
              cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q  <= '0;
      valid_q   <= '0;
      dp_q      <= '0;
      pend      <= '0;
      upd_q     <= 1'b0;
      idx_q     <= '0;
      seg_err_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++)
        timer[i] <= '0;
    end else begin
      upd_q     <= 1'b0;
      seg_err_q <= 1'b0;
      valid_q   <= valid_n;
      pend      <= pend_n;
      if (cap_en) begin
        if (dec_ok) begin
          digits_q[{k, 2'b00} +: 4] <= dec_val;
          dp_q[k] <= ~snap.ca[0];
        end else begin
          seg_err_q <= 1'b1;
        end
      end
      if (cap_upd) begin
        upd_q <= 1'b1;
        idx_q <= k;
      end else if (sel_hit) begin
        upd_q <= 1'b1;
        idx_q <= sel;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_en && dec_ok && IW'(i) == k)
          timer[i] <= '0;
        else if (timer[i] != TW'(TIMEOUT_CYC))
          timer[i] <= timer[i] + 1'b1;
      end
    end
  end

  assign bus.digits    = digits_q;
  assign bus.dig_valid = valid_q;
  assign bus.dp_out    = dp_q;
  assign bus.upd       = upd_q;
  assign bus.upd_idx   = idx_q;
  assign bus.seg_err   = seg_err_q;
  assign bus.an_err    = an_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: expected pulses are
// queued with their due cycle and matched at each negedge.
module tb_seg_scan_capture;
  import seg_pkg::*;

  localparam int ND  = 8;
  localparam int SC  = 16;
  localparam int TO  = 32768;
  localparam int LAT = SC + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_capture #(
    .NUM_DIGITS  (ND),
    .STABLE_CYC  (SC),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int   cyc;
    int   idx;
    int   val;
    logic vld;
  } upd_t;

  upd_t uq[$];
  int   sq[$];
  int   aq[$];
  int   cyc;
  int   n_vec;
  int   n_bad;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0d",
               tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    upd_t e;
    int   c;
    if (rst_n) begin
      if (bus.upd) begin
        if (uq.size() == 0) begin
          chk("spur_upd", 32'(bus.upd), 0);
        end else begin
          e = uq.pop_front();
          chk("upd_cyc", cyc, e.cyc);
          chk("upd_idx", 32'(bus.upd_idx), e.idx);
          chk("upd_val", 32'(bus.digits[e.idx*4 +: 4]), e.val);
          chk("upd_vld", 32'(bus.dig_valid[e.idx]), 32'(e.vld));
        end
      end
      if (bus.seg_err) begin
        if (sq.size() == 0) begin
          chk("spur_seg", 32'(bus.seg_err), 0);
        end else begin
          c = sq.pop_front();
          chk("seg_cyc", cyc, c);
        end
      end
      if (bus.an_err) begin
        if (aq.size() == 0) begin
          chk("spur_an", 32'(bus.an_err), 0);
        end else begin
          c = aq.pop_front();
          chk("an_cyc", cyc, c);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] a,
                     input logic [7:0] c,
                     output int at);
    @(negedge clk);
    bus.an = a;
    bus.ca = c;
    at = cyc;
  endtask

  task automatic exp_upd(input int at, input int idx,
                         input int val, input logic vld);
    upd_t e;
    e.cyc = at;
    e.idx = idx;
    e.val = val;
    e.vld = vld;
    uq.push_back(e);
  endtask

  task automatic drain(input string tag);
    idle(LAT + 4);
    chk(tag, uq.size() + sq.size() + aq.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dig"}, bus.digits, 0);
    chk({tag, "_vld"}, 32'(bus.dig_valid), 0);
    chk({tag, "_dp"},  32'(bus.dp_out), 0);
    chk({tag, "_upd"}, 32'(bus.upd), 0);
    chk({tag, "_idx"}, 32'(bus.upd_idx), 0);
    chk({tag, "_se"},  32'(bus.seg_err), 0);
    chk({tag, "_ae"},  32'(bus.an_err), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.an = SEG_BLANK;
    bus.ca = SEG_BLANK;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog expired @%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, r;
    bus.an = SEG_BLANK;
    bus.ca = SEG_BLANK;
    idle(3);
    chk_zero("rst");
    rst_n = 1'b1;

    put(8'hFE, SEG_CODE_7, t);
    exp_upd(t + LAT, 0, 7, 1'b1);
    idle(10000);
    put(8'hFD, SEG_CODE_3, t1);
    exp_upd(t1 + LAT, 1, 3, 1'b1);
    idle(10000);
    chk("scan_dig", 32'(bus.digits[7:0]), 32'h37);
    chk("scan_vld", 32'(bus.dig_valid), 32'h03);
    chk("scan_dp", 32'(bus.dp_out), 0);
    chk("scan_q", uq.size(), 0);

    put(SEG_BLANK, SEG_BLANK, r);
    exp_upd(t + LAT + TO, 0, 7, 1'b0);
    exp_upd(t1 + LAT + TO, 1, 3, 1'b0);
    idle(TO + 10);
    chk("tout_vld", 32'(bus.dig_valid), 0);
    chk("tout_q", uq.size(), 0);

    do_reset();
    put(8'hFE, SEG_CODE_7, t);
    idle(4);
    for (int i = 0; i < SC - 1; i++)
      put(8'hFE, (i % 2 == 1) ? SEG_CODE_7 : SEG_CODE_3, t);
    put(8'hFE, SEG_CODE_7, t);
    exp_upd(t + LAT, 0, 7, 1'b1);
    drain("glitch_q");

    do_reset();
    put(8'hFE, SEG_CODE_7, t);
    exp_upd(t + LAT, 0, 7, 1'b1);
    idle(LAT + 2);
    put(8'hFC, SEG_CODE_7, t);
    aq.push_back(t + 3);
    put(8'hFE, SEG_CODE_7, t);
    drain("anerr_q");
    put(8'hFE, SEG_BLANK, t);
    exp_upd(t + LAT, 0, 7, 1'b0);
    sq.push_back(t + LAT);
    drain("segerr_q");
    chk("segerr_vld", 32'(bus.dig_valid), 0);

    do_reset();
    put(8'hFE, SEG_CODE_9, t);
    exp_upd(t + LAT, 0, 9, 1'b1);
    idle(29);
    put(8'hFD, SEG_CODE_9, t);
    exp_upd(t + LAT, 1, 9, 1'b1);
    idle(29);
    put(8'hFE, SEG_CODE_0, t);
    exp_upd(t + LAT, 0, 0, 1'b1);
    idle(29);
    put(8'hFD, 8'h02, t);
    exp_upd(t + LAT, 1, 0, 1'b1);
    idle(29);
    put(8'hFB, SEG_CODE_6B, t);
    exp_upd(t + LAT, 2, 6, 1'b1);
    drain("roll_q");
    chk("roll_dig", 32'(bus.digits[11:0]), 32'h600);
    chk("roll_dp", 32'(bus.dp_out), 32'h02);
    chk("roll_vld", 32'(bus.dig_valid), 32'h07);

    put(8'hFE, SEG_CODE_1, t);
    idle(8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("mid");
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    exp_upd(r + LAT, 0, 1, 1'b1);
    drain("mid_q");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
